// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Reset and lock supervisor for the system clock PLL. Runs on the free-running
// reference clock, pulses the PLL reset, filters the PLL lock indication and
// releases the system reset only once lock has held for a full filter window.
// Lock timeouts re-pulse the PLL reset and are counted in retry_cnt. Lock
// losses while running also re-pulse the PLL reset and are counted in
// loss_cnt. Both counters saturate at 255.
//
// Ports
//   refclk       in   free-running reference clock (the only clock)
//   rst          in   synchronous active-high reset
//   locked_in    in   PLL locked output, asynchronous to refclk
//   pll_rst      out  reset to the PLL, active-high, registered
//   sys_reset    out  system reset, active-high, registered (low only in RUN)
//   pll_ok       out  high while in RUN, registered
//   retry_cnt    out  lock timeouts since rst, saturating at 255
//   loss_cnt     out  lock losses seen in RUN since rst, saturating at 255
//   o_dbg_state  out  current FSM state (0 PLL_RESET, 1 WAIT_LOCK,
//                     2 FILTER, 3 RUN) for debug and checkers
//
// There are no handshakes on this block: every input is a level and every
// output is a registered level.
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_in,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       pll_ok,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [1:0] o_dbg_state
);

  // One shared cycle counter. Its largest terminal value is max(params)-1,
  // so $clog2(max) bits are enough (all parameters are at least 2).
  localparam int C_MAX_AB = (RST_PULSE_CYCLES > LOCK_FILTER_CYCLES) ?
                            RST_PULSE_CYCLES : LOCK_FILTER_CYCLES;
  localparam int C_MAX    = (C_MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                            C_MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW       = $clog2(C_MAX);

  localparam logic [CW-1:0] C_RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] C_FILTER_LAST  = CW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CW-1:0] C_TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RESET = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_FILTER    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  // Registers
  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pll_rst;
  logic          r_sys_reset;
  logic          r_pll_ok;
  logic [7:0]    r_retry_cnt;
  logic [7:0]    r_loss_cnt;

  // Combinational next-state signals
  logic          w_locked_s;
  state_t        w_next_state;
  logic          w_state_change;
  logic          w_timeout;
  logic          w_loss;

  // Second synchronizer flop is the only view of lock the FSM ever uses.
  assign w_locked_s = r_sync2;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    w_loss       = 1'b0;

    case (r_state)
      S_PLL_RESET: begin
        if (r_cnt == C_RST_LAST) begin
          w_next_state = S_WAIT_LOCK;
        end
      end

      S_WAIT_LOCK: begin
        // Lock seen on the terminal cycle still wins over the timeout.
        if (w_locked_s) begin
          w_next_state = S_FILTER;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          w_next_state = S_PLL_RESET;
          w_timeout    = 1'b1;
        end
      end

      S_FILTER: begin
        // A drop on the terminal cycle still aborts the window: the glitch
        // test comes first so completion can never mask it.
        if (!w_locked_s) begin
          w_next_state = S_WAIT_LOCK;
        end else if (r_cnt == C_FILTER_LAST) begin
          w_next_state = S_RUN;
        end
      end

      S_RUN: begin
        if (!w_locked_s) begin
          w_next_state = S_PLL_RESET;
          w_loss       = 1'b1;
        end
      end

      default: begin
        w_next_state = S_PLL_RESET;
      end
    endcase
  end

  assign w_state_change = (w_next_state != r_state);

  // ---------------------------------------------------------------------------
  // State, counter, synchronizer and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_state     <= S_PLL_RESET;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_reset <= 1'b1;
      r_pll_ok    <= 1'b0;
      r_retry_cnt <= 8'd0;
      r_loss_cnt  <= 8'd0;
    end else begin
      r_sync1 <= locked_in;
      r_sync2 <= r_sync1;
      r_state <= w_next_state;

      // The counter is meaningless in RUN, so it parks at 0 there instead of
      // free-running and wrapping.
      if (w_state_change || (r_state == S_RUN)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      // Outputs decode the next state so they move on the transition edge.
      r_pll_rst   <= (w_next_state == S_PLL_RESET);
      r_sys_reset <= (w_next_state != S_RUN);
      r_pll_ok    <= (w_next_state == S_RUN);

      if (w_timeout && (r_retry_cnt != 8'hFF)) begin
        r_retry_cnt <= r_retry_cnt + 8'd1;
      end
      if (w_loss && (r_loss_cnt != 8'hFF)) begin
        r_loss_cnt <= r_loss_cnt + 8'd1;
      end
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_reset   = r_sys_reset;
  assign pll_ok      = r_pll_ok;
  assign retry_cnt   = r_retry_cnt;
  assign loss_cnt    = r_loss_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset and lock supervisor for the system clock PLL. Runs on the free-running 50 MHz reference clock and drives the PLL's `rst` input. It consumes the PLL's `locked` output, filters it, and releases a synchronous system reset only after lock has been stable. It re-pulses the PLL reset on lock timeout or lock loss, and counts both events for software-visible status.

## Interface
- `RST_PULSE_CYCLES`, 16: width of each PLL reset pulse, in refclk cycles; ≥2.
- `LOCK_FILTER_CYCLES`, 1024: consecutive synchronized-locked cycles required before release; ≥2.
- `LOCK_TIMEOUT_CYCLES`, 100000: cycles to wait for lock after a PLL reset before retrying; ≥2.
- `refclk` in 1: free-running reference clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `locked_in` in 1: PLL locked output; asynchronous to refclk.
- `pll_rst` out 1: reset to the PLL, active-high, registered.
- `sys_reset` out 1: system reset, active-high, registered.
- `pll_ok` out 1: high while in RUN, registered.
- `retry_cnt` out 8: lock timeouts since `rst`; saturates at 255.
- `loss_cnt` out 8: lock losses seen in RUN since `rst`; saturates at 255.

## Operation
- `locked_in` passes through a 2-flop synchronizer to give `locked_s`. Only `locked_s` is used.
- There is one cycle counter `cnt`, sized for max(all parameters). It clears on every state change.
- States are PLL_RESET, WAIT_LOCK, FILTER and RUN.
- PLL_RESET: `pll_rst`=1. After `RST_PULSE_CYCLES` cycles in the state, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0.
  - If `locked_s`=1, go to FILTER.
  - Otherwise, when `cnt`==`LOCK_TIMEOUT_CYCLES`-1, go to PLL_RESET and increment `retry_cnt` (saturating).
- FILTER:
  - If `locked_s`=0, go to WAIT_LOCK. The timeout window restarts and no counter increments.
  - When `cnt`==`LOCK_FILTER_CYCLES`-1 with `locked_s`=1, go to RUN.
- RUN: `sys_reset`=0 and `pll_ok`=1. If `locked_s`=0, go to PLL_RESET and increment `loss_cnt` (saturating).
- `sys_reset`=1 in every state except RUN. It is never deasserted without a completed filter window.
- Outputs are registered from the next-state value, so an output changes on the same edge as its state transition.
- Reset, and any `rst` mid-operation:
  - State goes to PLL_RESET and `cnt`=0.
  - `pll_rst`=1, `sys_reset`=1, `pll_ok`=0.
  - `retry_cnt`=0, `loss_cnt`=0.
  - Synchronizer flops clear to 0.
- `rst` has priority over every transition and counter increment.

## Timing
- The PLL reset pulse is exactly `RST_PULSE_CYCLES` cycles. It is counted from the first edge with `rst`=0, or from the entry edge on a retry or loss.
- Lock-acquisition latency: let edge k be the first edge sampling `locked_in`=1 while in WAIT_LOCK with the level held.
  - `locked_s` rises after edge k+1.
  - FILTER is entered at edge k+2.
  - RUN is entered, and `sys_reset` falls, at edge k+2+`LOCK_FILTER_CYCLES`.
- Lock-loss latency: if `locked_in` is first sampled 0 at edge j while in RUN, then at edge j+2:
  - `sys_reset` and `pll_rst` rise;
  - `pll_ok` falls;
  - `loss_cnt` increments.
- A `locked_s` glitch in FILTER on the cycle `cnt` would reach terminal still returns to WAIT_LOCK. Glitch wins over completion.
- Counter saturation: at 255 a further event leaves the value at 255. The state transition still occurs.
- A loss in RUN does not touch `retry_cnt`. A timeout does not touch `loss_cnt`.

## Test plan
All scenarios use `RST_PULSE_CYCLES`=4, `LOCK_FILTER_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32.

- Reset then clean lock: hold `rst` for 3 cycles; raise `locked_in` at cycle 10 after release.
  - `pll_rst` is high for exactly 4 cycles after release.
  - `sys_reset` falls 10 edges after the first edge sampling lock.
  - `pll_ok`=1; both counters are 0.
- No lock: keep `locked_in`=0 for 200 cycles.
  - The PLL reset pulse repeats every 36 cycles (4+32).
  - `retry_cnt` increments once per timeout.
  - `sys_reset` stays 1 throughout.
- Filter glitch: lock, then drop `locked_in` for 1 cycle during FILTER at `cnt`=5.
  - FSM returns to WAIT_LOCK, and `sys_reset` stays 1.
  - After `locked_in` is restored, release occurs a full 8-cycle filter window later.
- Loss in RUN: reach RUN, then drop `locked_in`.
  - `sys_reset`=1 and `pll_rst`=1 two edges later.
  - `loss_cnt`=1.
  - The 4-cycle pulse is followed by re-lock and release.
- Saturation: force 260 lock losses.
  - `loss_cnt` stays at 255; the FSM keeps cycling correctly.
- Mid-operation reset: assert `rst` for 1 cycle while in RUN with `loss_cnt`=3.
  - Next edge: `sys_reset`=1, `pll_rst`=1, `pll_ok`=0, counters = 0.
  - The full sequence restarts.
